// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
// States, ALU ops, opcodes and datapath mux select encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_LUI,
        S_BRANCH,
        S_JALR,
        S_JUMP,
        S_TRAP
    } mc_state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        ALU_CLS_ADD,
        ALU_CLS_SUB,
        ALU_CLS_R,
        ALU_CLS_I
    } alu_cls_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle FSM (master) and datapath (slave).
interface multicycle_ctrl_if;

    logic       run;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       func75;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [2:0] ImmSrc;
    logic       Halted;

    modport master (
        input  run, opcode, funct3, func75, Zero,
        output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Halted
    );

    modport slave (
        output run, opcode, funct3, func75, Zero,
        input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Halted
    );

endinterface

// File: rtl/mc_alu_decoder.sv
// ALU operation decode from state class and instruction fields.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
(
    input  alu_cls_t   cls,
    input  logic [2:0] funct3,
    input  logic       func75,
    output alu_op_t    op,
    output logic       illegal
);

    always_comb begin
        op      = ALU_ADD;
        illegal = 1'b0;
        unique case (cls)
            ALU_CLS_ADD: op = ALU_ADD;
            ALU_CLS_SUB: op = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000: op = (cls == ALU_CLS_R && func75) ? ALU_SUB : ALU_ADD;
                    3'b001: op = ALU_SLL;
                    3'b010: op = ALU_SLT;
                    3'b011: illegal = 1'b1;
                    3'b100: op = ALU_XOR;
                    3'b101: begin
                        op      = ALU_SRL;
                        illegal = func75;
                    end
                    3'b110: op = ALU_OR;
                    default: op = ALU_AND;
                endcase
                // R-type only defines func75=1 for sub (and sra, unsupported)
                if (cls == ALU_CLS_R && func75 && funct3 != 3'b000)
                    illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core.
// Define MC_PERF_CNT_EN to add the cycle_cnt / instret_cnt counters.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter mc_state_t RESET_STATE = S_FETCH
) (
    input  logic clk,
    input  logic rst,
    multicycle_ctrl_if.master bus
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    mc_state_t state;
    mc_state_t nxt;
    logic      halted;
    alu_cls_t  cls;
    alu_op_t   alu_op;
    logic      alu_bad;
    logic      beqne;

    assign beqne = (bus.funct3[2:1] == 2'b00);

    mc_alu_decoder u_alu_dec (
        .cls     (cls),
        .funct3  (bus.funct3),
        .func75  (bus.func75),
        .op      (alu_op),
        .illegal (alu_bad)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            S_FETCH:    if (bus.run) nxt = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_R:              nxt = S_EXEC_R;
                    OP_I:              nxt = S_EXEC_I;
                    OP_BRANCH:         nxt = S_BRANCH;
                    OP_JAL:            nxt = S_JUMP;
                    OP_JALR:           nxt = S_JALR;
                    OP_LUI:            nxt = S_LUI;
                    default:           nxt = S_TRAP;
                endcase
            end
            S_MEMADR:   nxt = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  nxt = S_MEMWB;
            S_MEMWB:    nxt = S_FETCH;
            S_MEMWRITE: nxt = S_FETCH;
            S_EXEC_R,
            S_EXEC_I:   nxt = alu_bad ? S_TRAP : S_ALUWB;
            S_LUI:      nxt = S_ALUWB;
            S_ALUWB:    nxt = S_FETCH;
            S_BRANCH:   nxt = beqne ? S_FETCH : S_TRAP;
            S_JALR:     nxt = S_JUMP;
            S_JUMP:     nxt = S_ALUWB;
            default:    nxt = S_TRAP;
        endcase
    end

    always_comb begin
        cls           = ALU_CLS_ADD;
        bus.PCWrite   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.ResultSrc = RES_ALUOUT;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_RD2;
        bus.ImmSrc    = IMM_I;
        unique case (state)
            S_FETCH: begin
                bus.IRWrite   = bus.run;
                bus.PCWrite   = bus.run;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURES;
            end
            S_DECODE: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
                bus.ImmSrc  = (bus.opcode == OP_JAL) ? IMM_J : IMM_B;
            end
            S_MEMADR: begin
                bus.ALUSrcA = SRCA_RD1;
                bus.ALUSrcB = SRCB_IMM;
                bus.ImmSrc  = (bus.opcode == OP_LOAD) ? IMM_I : IMM_S;
            end
            S_MEMREAD:  bus.AdrSrc = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                bus.RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S_EXEC_R: begin
                bus.ALUSrcA = SRCA_RD1;
                cls         = ALU_CLS_R;
            end
            S_EXEC_I: begin
                bus.ALUSrcA = SRCA_RD1;
                bus.ALUSrcB = SRCB_IMM;
                cls         = ALU_CLS_I;
            end
            S_LUI: begin
                bus.ALUSrcA = SRCA_ZERO;
                bus.ALUSrcB = SRCB_IMM;
                bus.ImmSrc  = IMM_U;
            end
            S_ALUWB:    bus.RegWrite = 1'b1;
            S_BRANCH: begin
                bus.ALUSrcA = SRCA_RD1;
                cls         = ALU_CLS_SUB;
                bus.PCWrite = beqne & (bus.Zero ^ bus.funct3[0]);
            end
            S_JALR: begin
                bus.ALUSrcA = SRCA_RD1;
                bus.ALUSrcB = SRCB_IMM;
            end
            S_JUMP: begin
                bus.PCWrite = 1'b1;
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
            end
            default: ;
        endcase
        bus.ALUControl = alu_op;
        bus.Halted     = halted;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RESET_STATE;
            halted <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt == S_TRAP)
                halted <= 1'b1;
        end
    end

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (bus.run && !halted)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (nxt == S_FETCH && state != S_FETCH)
                instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control vectors.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    multicycle_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    typedef struct {
        string       tag;
        logic [17:0] v;
        logic [17:0] m;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    localparam logic [17:0] ALL   = 18'h3FFFF;
    localparam logic [17:0] NOALU = 18'h3FF8F;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // {PCWrite,AdrSrc,IRWrite,MemWrite,RegWrite,ResultSrc,A,B,ALU,Imm,Halted}
    function automatic logic [17:0] cv(int pcw, int adr, int irw, int mw,
                                       int rw, int rs, int a, int b,
                                       int alu, int imm, int h);
        return {pcw[0], adr[0], irw[0], mw[0], rw[0], rs[1:0],
                a[1:0], b[1:0], alu[2:0], imm[2:0], h[0]};
    endfunction

    function automatic logic [17:0] obs();
        return {bus.PCWrite, bus.AdrSrc, bus.IRWrite, bus.MemWrite,
                bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
                bus.ALUControl, bus.ImmSrc, bus.Halted};
    endfunction

    function automatic logic [17:0] fetch_v(int run);
        return cv(run, 0, run, 0, 0, 2, 0, 2, 0, 0, 0);
    endfunction

    task automatic push(string tag, logic [17:0] v, logic [17:0] m = ALL);
        sb.push_back('{tag, v, m});
    endtask

    task automatic push_fd(string t, int imm);
        push({t, ".fetch"}, fetch_v(1));
        push({t, ".dec"}, cv(0, 0, 0, 0, 0, 0, 1, 1, 0, imm, 0));
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            check(e.tag, 32'(obs() & e.m), 32'(e.v & e.m));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ins(logic [31:0] ir, logic z);
        bus.opcode = ir[6:0];
        bus.funct3 = ir[14:12];
        bus.func75 = ir[30];
        bus.Zero   = z;
        drain();
    endtask

    task automatic rst_pulse(string t);
        rst = 1'b1;
        push(t, fetch_v(1));
        drain();
        rst = 1'b0;
    endtask

    task automatic r_op(string t, logic [31:0] ir, int alu);
        push_fd(t, 2);
        push({t, ".ex"}, cv(0, 0, 0, 0, 0, 0, 2, 0, alu, 0, 0));
        push({t, ".wb"}, cv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        ins(ir, 1'b0);
    endtask

    task automatic i_op(string t, logic [31:0] ir, int alu);
        push_fd(t, 2);
        push({t, ".ex"}, cv(0, 0, 0, 0, 0, 0, 2, 1, alu, 0, 0));
        push({t, ".wb"}, cv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        ins(ir, 1'b0);
    endtask

    task automatic br(string t, logic [31:0] ir, logic z, int pcw);
        push_fd(t, 2);
        push({t, ".br"}, cv(pcw, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0));
        ins(ir, z);
    endtask

    initial begin
        rst        = 1'b1;
        bus.run    = 1'b0;
        bus.opcode = '0;
        bus.funct3 = '0;
        bus.func75 = 1'b0;
        bus.Zero   = 1'b0;
        @(posedge clk);
        #1;
        push("reset", fetch_v(0));
        drain();
        rst = 1'b0;
`ifdef MC_PERF_CNT_EN
        check("cyc.reset", cycle_cnt, 32'd0);
        check("ret.reset", instret_cnt, 32'd0);
`endif
        for (int i = 0; i < 10; i++)
            push("idle", fetch_v(0));
        drain();
        bus.run = 1'b1;

        r_op("add", 32'h0000_0033, 0);
        r_op("sub", 32'h4000_0033, 1);
        r_op("xor", 32'h0000_4033, 4);
`ifdef MC_PERF_CNT_EN
        check("cyc.3r", cycle_cnt, 32'd12);
        check("ret.3r", instret_cnt, 32'd3);
`endif

        push_fd("lw", 2);
        push("lw.adr", cv(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        push("lw.rd", cv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push("lw.wb", cv(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        ins(32'h0000_A303, 1'b0);

        push_fd("sw", 2);
        push("sw.adr", cv(0, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
        push("sw.wr", cv(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        ins(32'h0000_2023, 1'b0);

        br("beq.z1", 32'h0000_0063, 1'b1, 1);
        br("bne.z1", 32'h0000_1063, 1'b1, 0);
        br("beq.z0", 32'h0000_0063, 1'b0, 0);
        br("bne.z0", 32'h0000_1063, 1'b0, 1);

        push_fd("jal", 3);
        push("jal.jmp", cv(1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
        push("jal.wb", cv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        ins(32'h0000_006F, 1'b0);

        push_fd("jalr", 2);
        push("jalr.tgt", cv(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        push("jalr.jmp", cv(1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
        push("jalr.wb", cv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        ins(32'h0000_0067, 1'b0);

        push_fd("lui", 2);
        push("lui.ex", cv(0, 0, 0, 0, 0, 0, 3, 1, 0, 4, 0));
        push("lui.wb", cv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        ins(32'h0000_0037, 1'b0);

        i_op("addi", 32'h0000_0013, 0);
        i_op("srli", 32'h0000_5013, 7);
        i_op("slti", 32'h0000_2013, 5);
        i_op("ori", 32'h0000_6013, 3);
        i_op("slli.f75", 32'h4000_1013, 6);
        r_op("sll", 32'h0000_1033, 6);
        r_op("and", 32'h0000_7033, 2);

        push_fd("sltu", 2);
        push("sltu.ex", cv(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0), NOALU);
        push("sltu.trap", cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        push("sltu.trap", cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        ins(32'h0000_3033, 1'b0);
        rst_pulse("rst.after.sltu");

        push_fd("blt", 2);
        push("blt.br", cv(0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0));
        push("blt.trap", cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        ins(32'h0000_4063, 1'b1);
        rst_pulse("rst.after.blt");

        push_fd("srai", 2);
        push("srai.ex", cv(0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0), NOALU);
        push("srai.trap", cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        ins(32'h4000_5013, 1'b0);
        rst_pulse("rst.after.srai");

        push_fd("sw2", 2);
        push("sw2.adr", cv(0, 0, 0, 0, 0, 0, 2, 1, 0, 1, 0));
        ins(32'h0000_2023, 1'b0);
        @(negedge clk);
        check("sw2.wr", 32'(obs()), 32'(cv(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0)));
        #2 rst = 1'b1;
        #1 check("rst.mid.store", 32'(obs()), 32'(fetch_v(1)));
        @(posedge clk);
        #1 rst = 1'b0;

        push_fd("ill7f", 2);
        for (int i = 0; i < 4; i++)
            push("ill7f.trap", cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        ins(32'h0000_007F, 1'b0);
`ifdef MC_PERF_CNT_EN
        check("cyc.halt", cycle_cnt, 32'd2);
        check("ret.halt", instret_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
